// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for add_pipe
interface add_pipe_if #(
    parameter int WIDTH_P = 32
);
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] a_i;
    logic [WIDTH_P-1:0] b_i;
    logic               cin_i;
    logic               sub_i;
    logic [1:0]         mode_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH_P-1:0] sum_o;
    logic               carry_o;
    logic               overflow_o;

    modport master (
        output valid_i, a_i, b_i, cin_i, sub_i, mode_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );

    modport slave (
        input  valid_i, a_i, b_i, cin_i, sub_i, mode_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );
endinterface

// File: rtl/add_pipe.sv
// add_pipe: elastic pipelined adder/subtractor, one CW-bit carry chunk per stage, saturation in the last stage
module add_pipe #(
    parameter int WIDTH_P  = 32,
    parameter int STAGES_P = 4
) (
    input logic       clk_i,
    input logic       reset_i,
    add_pipe_if.slave bus
);
    localparam int CW = WIDTH_P / STAGES_P;
    localparam int L  = STAGES_P - 1;

    logic [WIDTH_P-1:0]  a_x [STAGES_P];
    logic [WIDTH_P-1:0]  b_x [STAGES_P];
    logic [WIDTH_P-1:0]  s_x [STAGES_P];
    logic [WIDTH_P-1:0]  a_d [STAGES_P];
    logic [WIDTH_P-1:0]  b_d [STAGES_P];
    logic [WIDTH_P-1:0]  s_d [STAGES_P];
    logic [WIDTH_P-1:0]  a_q [STAGES_P];
    logic [WIDTH_P-1:0]  b_q [STAGES_P];
    logic [WIDTH_P-1:0]  s_q [STAGES_P];
    logic [1:0]          mode_x [STAGES_P];
    logic [1:0]          mode_d [STAGES_P];
    logic [1:0]          mode_q [STAGES_P];
    logic [STAGES_P-1:0] v_x, v_d, v_q;
    logic [STAGES_P-1:0] c_x, c_d, c_q;
    logic [STAGES_P-1:0] sub_x, sub_d, sub_q;
    logic [STAGES_P-1:0] en;
    logic [CW:0]         p;
    logic [WIDTH_P-1:0]  s_r;
    logic                e, uo, ovs, ovf_d, ovf_q;

    // Stage 0 sees the preprocessed operands; every later stage sees its predecessor's registers
    assign a_x[0]    = bus.a_i;
    assign b_x[0]    = bus.sub_i ? ~bus.b_i : bus.b_i;
    assign s_x[0]    = '0;
    assign c_x[0]    = bus.sub_i ^ bus.cin_i;
    assign sub_x[0]  = bus.sub_i;
    assign mode_x[0] = bus.mode_i;
    assign v_x[0]    = bus.valid_i;

    for (genvar k = 1; k < STAGES_P; k++) begin : g_link
        assign a_x[k]    = a_q[k-1];
        assign b_x[k]    = b_q[k-1];
        assign s_x[k]    = s_q[k-1];
        assign c_x[k]    = c_q[k-1];
        assign sub_x[k]  = sub_q[k-1];
        assign mode_x[k] = mode_q[k-1];
        assign v_x[k]    = v_q[k-1];
    end

    always_comb begin
        e = bus.ready_i;
        for (int k = L; k >= 0; k--) begin
            e     = ~v_q[k] | e;
            en[k] = e;
        end
        p   = '0;
        s_r = '0;
        for (int k = 0; k < STAGES_P; k++) begin
            p                = {1'b0, a_x[k][k*CW +: CW]} + {1'b0, b_x[k][k*CW +: CW]} + (CW+1)'(c_x[k]);
            s_r              = s_x[k];
            s_r[k*CW +: CW]  = p[CW-1:0];
            v_d[k]           = en[k] ? v_x[k] : v_q[k];
            a_d[k]           = en[k] ? a_x[k] : a_q[k];
            b_d[k]           = en[k] ? b_x[k] : b_q[k];
            sub_d[k]         = en[k] ? sub_x[k] : sub_q[k];
            mode_d[k]        = en[k] ? mode_x[k] : mode_q[k];
            c_d[k]           = en[k] ? p[CW] : c_q[k];
            s_d[k]           = en[k] ? s_r : s_q[k];
        end
        // p and s_r now hold the final stage's raw carry and sum
        uo     = sub_x[L] ? ~p[CW] : p[CW];
        ovs    = (a_x[L][WIDTH_P-1] == b_x[L][WIDTH_P-1]) && (s_r[WIDTH_P-1] != a_x[L][WIDTH_P-1]);
        s_d[L] = ~en[L] ? s_q[L] :
                 (mode_x[L] == 2'b01) && uo  ? {WIDTH_P{~sub_x[L]}} :
                 (mode_x[L] == 2'b10) && ovs ? {a_x[L][WIDTH_P-1], {(WIDTH_P-1){~a_x[L][WIDTH_P-1]}}} :
                 s_r;
        ovf_d  = ~en[L] ? ovf_q : (mode_x[L] == 2'b10) ? ovs : uo;
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < STAGES_P; k++) begin
            a_q[k]    <= reset_i ? '0 : a_d[k];
            b_q[k]    <= reset_i ? '0 : b_d[k];
            s_q[k]    <= reset_i ? '0 : s_d[k];
            mode_q[k] <= reset_i ? '0 : mode_d[k];
        end
        v_q   <= reset_i ? '0 : v_d;
        c_q   <= reset_i ? '0 : c_d;
        sub_q <= reset_i ? '0 : sub_d;
        ovf_q <= reset_i ? 1'b0 : ovf_d;
    end

    assign bus.ready_o    = en[0] & ~reset_i;
    assign bus.valid_o    = v_q[L];
    assign bus.sum_o      = s_q[L];
    assign bus.carry_o    = c_q[L];
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe with 1-, 4- and 32-stage builds
module tb_add_pipe;
    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    localparam longint SMAX = (64'sd1 <<< 31) - 1;
    localparam longint SMIN = -(64'sd1 <<< 31);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_pipe_if #(.WIDTH_P(32)) bus4 ();
    add_pipe_if #(.WIDTH_P(32)) bus1 ();
    add_pipe_if #(.WIDTH_P(32)) bus32 ();

    add_pipe #(.WIDTH_P(32), .STAGES_P(4))  dut4  (.clk_i(clk), .reset_i(rst), .bus(bus4));
    add_pipe #(.WIDTH_P(32), .STAGES_P(1))  dut1  (.clk_i(clk), .reset_i(rst), .bus(bus1));
    add_pipe #(.WIDTH_P(32), .STAGES_P(32)) dut32 (.clk_i(clk), .reset_i(rst), .bus(bus32));

    int   checks = 0;
    int   failures = 0;
    res_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, signed range computed on 64-bit integers
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                   input logic sub, input logic [1:0] mode);
        res_t        x;
        logic [32:0] u;
        longint      r;
        u   = sub ? {1'b0, a} - {1'b0, b} - 33'(cin) : {1'b0, a} + {1'b0, b} + 33'(cin);
        r   = sub ? longint'($signed(a)) - longint'($signed(b)) - longint'(cin)
                  : longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        x.s = u[31:0];
        x.c = sub ? ~u[32] : u[32];
        x.o = u[32];
        if (mode == 2'd1 && u[32]) x.s = sub ? 32'h0 : 32'hFFFF_FFFF;
        if (mode == 2'd2) begin
            x.o = (r > SMAX) || (r < SMIN);
            if (r > SMAX) x.s = 32'h7FFF_FFFF;
            if (r < SMIN) x.s = 32'h8000_0000;
        end
        return x;
    endfunction

    function automatic logic [31:0] rop();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: occupancy-based ready model, stall hold, in-order scoreboard, reset clearing
    logic        rst_seen = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] hs;
    logic        hc, ho;
    always @(negedge clk) begin
        res_t x;
        if (rst_seen) begin
            chk("rst_valid", bus4.valid_o, 0);
            chk("rst_sum", bus4.sum_o, 0);
            chk("rst_carry", bus4.carry_o, 0);
            chk("rst_ovf", bus4.overflow_o, 0);
        end
        if (rst) begin
            chk("rst_ready", bus4.ready_o, 0);
            q.delete();
            stall = 1'b0;
        end else begin
            chk("ready", bus4.ready_o, (q.size() < 4) || bus4.ready_i);
            if (stall) begin
                chk("hold_valid", bus4.valid_o, 1);
                chk("hold_sum", bus4.sum_o, hs);
                chk("hold_carry", bus4.carry_o, hc);
                chk("hold_ovf", bus4.overflow_o, ho);
            end
            if (bus4.valid_o && bus4.ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual sum=%0h expected no output at %0t", bus4.sum_o, $time);
                end else begin
                    x = q.pop_front();
                    chk("sb_sum", bus4.sum_o, x.s);
                    chk("sb_carry", bus4.carry_o, x.c);
                    chk("sb_ovf", bus4.overflow_o, x.o);
                end
            end
            if (bus4.valid_i && bus4.ready_o)
                q.push_back(model(bus4.a_i, bus4.b_i, bus4.cin_i, bus4.sub_i, bus4.mode_i));
            stall = bus4.valid_o && !bus4.ready_i;
            hs    = bus4.sum_o;
            hc    = bus4.carry_o;
            ho    = bus4.overflow_o;
        end
        rst_seen = rst;
    end

    task automatic directed(input string nm, input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic sub, input logic [1:0] mode, input logic [31:0] es,
                            input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        bus4.a_i = a; bus4.b_i = b; bus4.cin_i = cin; bus4.sub_i = sub; bus4.mode_i = mode;
        bus4.valid_i = 1'b1; bus4.ready_i = 1'b1;
        @(posedge clk); #1;
        bus4.valid_i = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus4.valid_o && lat < 64);
        chk({nm, "_lat"}, lat, 4);
        chk({nm, "_sum"}, bus4.sum_o, es);
        chk({nm, "_carry"}, bus4.carry_o, ec);
        chk({nm, "_ovf"}, bus4.overflow_o, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int   sent, cyc, l1, l32;
        logic adv;
        logic [31:0] s1, s32;
        logic c1, c32;
        bus4.valid_i = 0; bus4.ready_i = 1; bus4.a_i = 0; bus4.b_i = 0;
        bus4.cin_i = 0; bus4.sub_i = 0; bus4.mode_i = 0;
        bus1.valid_i = 0; bus1.ready_i = 1; bus1.a_i = 0; bus1.b_i = 0;
        bus1.cin_i = 0; bus1.sub_i = 0; bus1.mode_i = 0;
        bus32.valid_i = 0; bus32.ready_i = 1; bus32.a_i = 0; bus32.b_i = 0;
        bus32.cin_i = 0; bus32.sub_i = 0; bus32.mode_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        directed("chunk_carry", 32'h0000_FFFF, 32'h1, 0, 0, 2'd0, 32'h0001_0000, 0, 0);
        directed("usat_add", 32'hFFFF_FFF0, 32'h20, 0, 0, 2'd1, 32'hFFFF_FFFF, 1, 1);
        directed("usat_sub", 32'd5, 32'd9, 0, 1, 2'd1, 32'h0, 0, 1);
        directed("ssat_add", 32'h7FFF_FFFF, 32'h1, 0, 0, 2'd2, 32'h7FFF_FFFF, 0, 1);
        directed("ssat_sub", 32'h8000_0000, 32'h1, 0, 1, 2'd2, 32'h8000_0000, 1, 1);
        directed("wrap_add", 32'h7FFF_FFFF, 32'h1, 0, 0, 2'd0, 32'h8000_0000, 0, 0);
        directed("mode3_add", 32'hFFFF_FFFF, 32'h2, 0, 0, 2'd3, 32'h1, 1, 1);

        sent = 0; cyc = 0; adv = 1'b1;
        while (sent < 100 && cyc < 5000) begin
            @(posedge clk); #1;
            bus4.ready_i = 1'($urandom_range(0, 1));
            if (adv) begin
                bus4.valid_i = 1'($urandom_range(0, 1));
                bus4.a_i = rop(); bus4.b_i = rop();
                bus4.cin_i = 1'($urandom_range(0, 1));
                bus4.sub_i = 1'($urandom_range(0, 1));
                bus4.mode_i = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            cyc++;
            adv = !bus4.valid_i || bus4.ready_o;
            if (bus4.valid_i && bus4.ready_o) sent++;
        end
        chk("rand_sent", sent, 100);
        @(posedge clk); #1;
        bus4.valid_i = 0; bus4.ready_i = 1;
        cyc = 0;
        while (q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("rand_drain", q.size(), 0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus4.a_i = 32'h1000 * (i + 1); bus4.b_i = 32'h5; bus4.cin_i = 0;
            bus4.sub_i = 0; bus4.mode_i = 0; bus4.valid_i = 1;
        end
        @(posedge clk); #1;
        bus4.valid_i = 0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_stale", bus4.valid_o, 0);
        end
        directed("post_rst", 32'h0000_FFFF, 32'h1, 0, 0, 2'd0, 32'h0001_0000, 0, 0);

        @(posedge clk); #1;
        bus1.a_i = 32'hFFFF_FFFF; bus1.b_i = 0; bus1.cin_i = 1; bus1.valid_i = 1;
        bus32.a_i = 32'hFFFF_FFFF; bus32.b_i = 0; bus32.cin_i = 1; bus32.valid_i = 1;
        @(negedge clk);
        chk("s1_ready", bus1.ready_o, 1);
        chk("s32_ready", bus32.ready_o, 1);
        @(posedge clk); #1;
        bus1.valid_i = 0; bus32.valid_i = 0;
        l1 = 0; l32 = 0; s1 = '1; s32 = '1; c1 = 0; c32 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus1.valid_o && l1 == 0) begin l1 = n; s1 = bus1.sum_o; c1 = bus1.carry_o; end
            if (bus32.valid_o && l32 == 0) begin l32 = n; s32 = bus32.sum_o; c32 = bus32.carry_o; end
        end
        chk("s1_lat", l1, 1);
        chk("s1_sum", s1, 0);
        chk("s1_carry", c1, 1);
        chk("s32_lat", l32, 32);
        chk("s32_sum", s32, 0);
        chk("s32_carry", c32, 1);

        @(negedge clk);
        chk("final_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
Parametrised, pipelined carry-chained adder/subtractor with valid/ready handshake, for the Sobel datapath (gradient sums, |Gx|+|Gy| magnitude).
- Operand width is split into STAGES_P equal chunks; one chunk is resolved per clock, and the carry between chunks is registered.
- Adds subtract, unsigned/signed saturation and overflow reporting.
- Full backpressure, with one result per cycle sustained.

Parameters:
- WIDTH_P, 32, operand/result width in bits; must be >= 2.
- STAGES_P, 4, pipeline depth and number of chunks; must divide WIDTH_P evenly, 1 <= STAGES_P <= WIDTH_P.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  input operands valid.
- ready_o  output  1  block can accept an input this cycle.
- a_i  input  WIDTH_P  operand A.
- b_i  input  WIDTH_P  operand B.
- cin_i  input  1  carry-in (add) or borrow-in (subtract).
- sub_i  input  1  0 = A+B+cin; 1 = A-B-cin.
- mode_i  input  2  00 wrap, 01 unsigned saturate, 10 signed saturate, 11 treated as 00.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- sum_o  output  WIDTH_P  result, possibly saturated.
- carry_o  output  1  raw carry out of the MSB (add); 1 = no borrow (subtract).
- overflow_o  output  1  overflow flag for the selected mode.

Behaviour:
- Transfer rules:
  - An input transfer occurs when valid_i && ready_o.
  - An output transfer occurs when valid_o && ready_i.
  - Data must not be dropped or duplicated.
- Operand preprocessing:
  - CW = WIDTH_P/STAGES_P.
  - Effective operands: Beff = sub_i ? ~b_i : b_i; Ceff = sub_i ? ~cin_i : cin_i.
- Stage k (k = 0..STAGES_P-1):
  - Adds chunk k of A and Beff with the registered carry from stage k-1 (Ceff for k=0).
  - Registers its sum chunk, its carry out, the not-yet-processed high chunks, the already-resolved low chunks, and sub_i/mode_i/operand MSBs.
  - Holds its own valid bit v[k].
  - The combinational carry chain per stage is exactly CW bits.
- Final stage: applies saturation before registering. Let s = raw sum, c = final carry, ovs = (A[msb] == Beff[msb]) && (s[msb] != A[msb]).
  - mode 00: sum_o = s; overflow_o = sub ? ~c : c.
  - mode 01, add: c=1 -> sum_o = all ones. Subtract: c=0 -> sum_o = 0. overflow_o = sub ? ~c : c.
  - mode 10: if ovs, sum_o = A[msb] ? 100..0 : 011..1. overflow_o = ovs.
  - carry_o is always the raw carry, independent of mode.
- Stage enables (elastic pipeline):
  - en[STAGES_P-1] = ~v[STAGES_P-1] | ready_i.
  - en[k] = ~v[k] | en[k+1].
  - ready_o = en[0].
  - A stage loads when its enable is set. The stage's valid becomes the upstream valid (valid_i for stage 0).
- Latency and throughput:
  - Latency is exactly STAGES_P cycles from input transfer to valid_o with ready_i held high.
  - Throughput is 1 result per cycle.
- Output hold: when valid_o=1 and ready_i=0, sum_o/carry_o/overflow_o/valid_o hold stable. Upstream stages keep filling until full; ready_o drops only when all STAGES_P stages are valid and the last is stalled.
- Simultaneous output transfer and full pipeline: the pipeline shifts and ready_o=1 in the same cycle (no bubble).
- Reset:
  - While reset_i=1: all v[k] <= 0, valid_o=0, ready_o=0.
  - Data registers clear, so sum_o=0, carry_o=0, overflow_o=0.
  - The cycle after reset deasserts: ready_o=1.
  - Reset mid-operation discards all in-flight results; no stale valid_o afterwards.
- STAGES_P=1: the block degenerates to a single registered adder with latency 1 and the same handshake.
- valid_o and the data outputs come straight from registers; no combinational path from a_i/b_i to outputs. ready_o depends combinationally on ready_i.

Test Plan:
1. WIDTH_P=32, STAGES_P=4, mode 00, ready_i=1: a=0x0000FFFF, b=0x00000001, cin=0 -> sum_o=0x00010000, carry_o=0, valid_o exactly 4 cycles after accept. This exercises carry crossing chunk boundaries.
2. Mode 01 add: a=0xFFFFFFF0, b=0x20 -> sum_o=0xFFFFFFFF, carry_o=1, overflow_o=1. Mode 01 sub: a=5, b=9 -> sum_o=0, carry_o=0, overflow_o=1.
3. Mode 10: a=0x7FFFFFFF, b=1 -> sum_o=0x7FFFFFFF, overflow_o=1. Mode 10 sub: a=0x80000000, b=1 -> sum_o=0x80000000, overflow_o=1. Mode 00 with the same add -> 0x80000000.
4. Back-to-back stream of 100 random vectors with random valid_i and ready_i toggling (50%) -> all results match a scoreboard in order with none lost. ready_o=0 only when 4 results are held and ready_i=0; outputs stay stable while stalled.
5. Fill the pipeline with 3 transactions, assert reset_i for 1 cycle -> valid_o=0, sum_o=0 during/after reset. No stale results emerge; the next input completes with latency 4.
6. STAGES_P=1 and STAGES_P=32 builds: a=0xFFFFFFFF, b=0, cin=1 -> sum_o=0, carry_o=1, latency 1 and 32 respectively.
